// File: rtl/keccak_arbiter.sv
// Round-robin front end that shares one keccak SHA3-512 core among N_REQ
// message streams: grant per message, pulse core reset, forward words, capture digest.

module keccak_arbiter_lane #(
  parameter int ID_W = 1,
  parameter int LANE = 0
) (
  input  logic            feed,
  input  logic [ID_W-1:0] g,
  input  logic            ready,
  input  logic            buffer_full,
  output logic            ack
);
  assign ack = feed & (g == ID_W'(LANE)) & ready & ~buffer_full;
endmodule

module keccak_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [64*N_REQ-1:0]  req_in,
  input  logic [N_REQ-1:0]     req_in_ready,
  input  logic [N_REQ-1:0]     req_is_last,
  input  logic [3*N_REQ-1:0]   req_byte_num,
  output logic [N_REQ-1:0]     req_ack,
  output logic                 k_reset,
  output logic [63:0]          k_in,
  output logic                 k_in_ready,
  output logic                 k_is_last,
  output logic [2:0]           k_byte_num,
  input  logic                 k_buffer_full,
  input  logic [511:0]         k_out,
  input  logic                 k_out_ready,
  output logic [511:0]         dig,
  output logic [ID_W-1:0]      dig_id,
  output logic                 dig_valid,
  output logic                 dig_err,
  output logic                 busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RST, FEED, WAIT, DONE} state_t;

  state_t                       state, state_nx;
  logic [N_REQ-1:0][63:0]       words;
  logic [N_REQ-1:0][2:0]        bnums;
  logic [ID_W-1:0]              g, last, pick, cand;
  logic                         found, feed;
  logic [CNT_W-1:0]             cnt;

  assign words = req_in;
  assign bnums = req_byte_num;

  // first requesting lane after the last grant, wrapping around
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last) + k) % N_REQ);
      if (!found && req_in_ready[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    keccak_arbiter_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
      .feed        (feed),
      .g           (g),
      .ready       (req_in_ready[i]),
      .buffer_full (k_buffer_full),
      .ack         (req_ack[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (found) state_nx = RST;
      RST:  state_nx = FEED;
      FEED: if (req_ack[g] & req_is_last[g]) state_nx = WAIT;
      WAIT: if (k_out_ready) state_nx = DONE;
            else if (cnt == CNT_W'(TIMEOUT - 1)) state_nx = IDLE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    k_reset    = reset | (state == RST);
    busy       = (state != IDLE);
    dig_valid  = (state == DONE);
    feed       = (state == FEED);
    k_in       = '0;
    k_in_ready = 1'b0;
    k_is_last  = 1'b0;
    k_byte_num = '0;
    if (feed) begin
      k_in       = words[g];
      k_in_ready = req_in_ready[g];
      k_is_last  = req_is_last[g];
      k_byte_num = bnums[g];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g       <= '0;
      last    <= ID_W'(N_REQ - 1);
      cnt     <= '0;
      dig     <= '0;
      dig_id  <= '0;
      dig_err <= 1'b0;
    end else begin
      dig_err <= 1'b0;
      case (state)
        IDLE: if (found) begin
          g    <= pick;
          last <= pick;
        end
        // a late digest wins over an expiring timeout
        WAIT: if (k_out_ready) begin
          dig    <= k_out;
          dig_id <= g;
          cnt    <= cnt + CNT_W'(1);
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          dig_err <= 1'b1;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        DONE: cnt <= '0;
        default: ;
      endcase
    end
  end
endmodule
